// File: rtl/weighted_voter.sv
// -----------------------------------------------------------------------------
// weighted_voter
//
// Session-based weighted voting accumulator. Three voter classes (normal, VIP,
// VVIP) each carry a fixed weight. Within a session every voter counts once,
// on the first cycle its bit is seen high. A small IDLE/OPEN/CLOSED FSM frames
// the session. The weighted total saturates at 2^RES_W-1.
//
// Ports:
//   clk     in   1       rising-edge clock
//   reset   in   1       asynchronous, active-low reset
//   start   in   1       open a new session (clears the session state)
//   stop    in   1       close the current session (wins over start)
//   np      in   NP_W    normal vote bits (weight 1)
//   vip     in   VIP_W   VIP vote bits (weight VIP_WEIGHT)
//   vvip    in   VVIP_W  VVIP vote bits (weight VVIP_WEIGHT)
//   result  out  RES_W   saturating weighted total of current/last session
//   voters  out  CW      number of distinct voters counted
//   open    out  1       high while a session is open
//   done    out  1       one-cycle pulse on entering CLOSED
//   sat     out  1       sticky: result was clamped this session
// -----------------------------------------------------------------------------
module weighted_voter #(
    parameter int NP_W        = 32,
    parameter int VIP_W       = 8,
    parameter int VVIP_W      = 1,
    parameter int VIP_WEIGHT  = 4,
    parameter int VVIP_WEIGHT = 16,
    parameter int RES_W       = 8,
    localparam int CW         = $clog2(NP_W + VIP_W + VVIP_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [NP_W-1:0]   np,
    input  logic [VIP_W-1:0]  vip,
    input  logic [VVIP_W-1:0] vvip,
    output logic [RES_W-1:0]  result,
    output logic [CW-1:0]     voters,
    output logic              open,
    output logic              done,
    output logic              sat
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_CLOSED = 2'd2
    } state_t;

    // Largest representable result, held at 32 bits so the compare against
    // the un-truncated sum below is done at full width.
    localparam logic [31:0] RES_MAX = 32'((64'd1 << RES_W) - 64'd1);

    state_t            state, state_next;
    logic [NP_W-1:0]   mask_np;
    logic [VIP_W-1:0]  mask_vip;
    logic [VVIP_W-1:0] mask_vvip;

    logic [NP_W-1:0]   new_np;
    logic [VIP_W-1:0]  new_vip;
    logic [VVIP_W-1:0] new_vvip;
    logic [31:0]       cnt_np, cnt_vip, cnt_vvip;
    logic [31:0]       delta, sum, new_voters;
    logic              over;

    // Only bits not yet in the session mask are new votes; everything is
    // kept at 32 bits until the final saturating compare.
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        new_np   = np & ~mask_np;
        new_vip  = vip & ~mask_vip;
        new_vvip = vvip & ~mask_vvip;
        cnt_np   = '0;
        cnt_vip  = '0;
        cnt_vvip = '0;
        for (int i = 0; i < NP_W; i++)   cnt_np   = cnt_np   + 32'(new_np[i]);
        for (int i = 0; i < VIP_W; i++)  cnt_vip  = cnt_vip  + 32'(new_vip[i]);
        for (int i = 0; i < VVIP_W; i++) cnt_vvip = cnt_vvip + 32'(new_vvip[i]);
        delta      = cnt_np + cnt_vip * 32'(VIP_WEIGHT) + cnt_vvip * 32'(VVIP_WEIGHT);
        sum        = 32'(result) + delta;
        over       = (sum > RES_MAX);
        new_voters = cnt_np + cnt_vip + cnt_vvip;
    end

    // Next-state logic; stop has priority over start while OPEN, and start
    // while OPEN is simply ignored.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_OPEN;
            S_OPEN:   if (stop)  state_next = S_CLOSED;
            S_CLOSED: if (start) state_next = S_OPEN;
            default:             state_next = S_IDLE;
        endcase
    end

    // NOTE: all state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    // NOTE: the vote masks are plain flops (not a memory), so they are reset
    // along with everything else and a reset mid-session leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mask_np   <= '0;
            mask_vip  <= '0;
            mask_vvip <= '0;
            result    <= '0;
            voters    <= '0;
            open      <= 1'b0;
            done      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state <= state_next;
            open  <= (state_next == S_OPEN);
            done  <= (state == S_OPEN) && stop;

            if (state == S_OPEN) begin
                // Votes present on the stop cycle still count.
                mask_np   <= mask_np | np;
                mask_vip  <= mask_vip | vip;
                mask_vvip <= mask_vvip | vvip;
                voters    <= voters + CW'(new_voters);
                if (over) begin
                    result <= RES_W'(RES_MAX);
                    sat    <= 1'b1;
                end else begin
                    result <= RES_W'(sum);
                end
            end else if (start) begin
                // Fresh session: votes on the start cycle itself are dropped.
                mask_np   <= '0;
                mask_vip  <= '0;
                mask_vvip <= '0;
                result    <= '0;
                voters    <= '0;
                sat       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weighted_voter.sv
// -----------------------------------------------------------------------------
// tb_weighted_voter
//
// Directed bench for weighted_voter. Two instances: the default build (RES_W=8)
// and a narrow build (RES_W=6) for saturation. Each stimulus step drives one
// cycle of inputs on the falling edge and pushes the hand-computed outputs
// expected after the next rising edge into a queue; a monitor pops one entry
// per rising edge and compares. Asynchronous-reset behaviour is checked
// directly between edges.
// -----------------------------------------------------------------------------
module tb_weighted_voter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, stop8, start6, stop6;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [0:0]  vvip;

    logic [7:0]  result8;
    logic [5:0]  voters8;
    logic        open8, done8, sat8;
    logic [5:0]  result6;
    logic [5:0]  voters6;
    logic        open6, done6, sat6;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string name;
        bit    sel;       // 0: RES_W=8 instance, 1: RES_W=6 instance
        int    result;
        int    voters;
        bit    open;
        bit    done;
        bit    sat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    weighted_voter u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .stop(stop8),
        .np(np), .vip(vip), .vvip(vvip),
        .result(result8), .voters(voters8), .open(open8), .done(done8), .sat(sat8)
    );

    weighted_voter #(.RES_W(6)) u_dut6 (
        .clk(clk), .reset(reset), .start(start6), .stop(stop6),
        .np(np), .vip(vip), .vvip(vvip),
        .result(result6), .voters(voters6), .open(open6), .done(done6), .sat(sat6)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus to the selected instance and queue the
    // outputs expected after the following rising edge.
    task automatic step(input string nm, input bit sel, input logic st, input logic sp,
                        input logic [31:0] n, input logic [7:0] v, input logic vv,
                        input int er, input int ev, input bit eo, input bit ed, input bit es);
        exp_t e;
        @(negedge clk);
        start8 = (sel == 1'b0) ? st : 1'b0;
        stop8  = (sel == 1'b0) ? sp : 1'b0;
        start6 = (sel == 1'b1) ? st : 1'b0;
        stop6  = (sel == 1'b1) ? sp : 1'b0;
        np     = n;
        vip    = v;
        vvip   = vv;
        e.name = nm; e.sel = sel; e.result = er; e.voters = ev;
        e.open = eo; e.done = ed; e.sat = es;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 1'b0) begin
                    check({e.name, "/result"}, int'(result8), e.result);
                    check({e.name, "/voters"}, int'(voters8), e.voters);
                    check({e.name, "/open"},   int'(open8),   int'(e.open));
                    check({e.name, "/done"},   int'(done8),   int'(e.done));
                    check({e.name, "/sat"},    int'(sat8),    int'(e.sat));
                end else begin
                    check({e.name, "/result"}, int'(result6), e.result);
                    check({e.name, "/voters"}, int'(voters6), e.voters);
                    check({e.name, "/open"},   int'(open6),   int'(e.open));
                    check({e.name, "/done"},   int'(done6),   int'(e.done));
                    check({e.name, "/sat"},    int'(sat6),    int'(e.sat));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        start8 = 1'b0; stop8 = 1'b0; start6 = 1'b0; stop6 = 1'b0;
        np = '0; vip = '0; vvip = '0;

        #3;
        check("rst/result", int'(result8), 0);
        check("rst/voters", int'(voters8), 0);
        check("rst/open",   int'(open8),   0);
        check("rst/done",   int'(done8),   0);
        check("rst/sat",    int'(sat8),    0);
        @(negedge clk);
        reset = 1'b1;

        //        name              sel st sp np            vip    vv  res vot o  d  s
        // 1: first session, basic weighting
        step("t1_start",        0, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t1_vote",         0, 0, 0, 32'h0000_000F, 8'h01, 0,  8, 5, 1, 0, 0);
        // 2: held and toggled bits are not recounted
        for (int i = 0; i < 3; i++)
            step("t2_hold",     0, 0, 0, 32'h0000_000F, 8'h01, 0,  8, 5, 1, 0, 0);
        step("t2_drop",         0, 0, 0, 32'h0,        8'h01, 0,  8, 5, 1, 0, 0);
        step("t2_reraise",      0, 0, 0, 32'h0000_000F, 8'h01, 0,  8, 5, 1, 0, 0);
        step("t2_vvip",         0, 0, 0, 32'h0000_000F, 8'h01, 1, 24, 6, 1, 0, 0);
        step("t5_close",        0, 0, 1, 32'h0,        8'h00, 0, 24, 6, 0, 1, 0);
        step("t5_closed_hold",  0, 0, 1, 32'h0000_00FF, 8'h00, 0, 24, 6, 0, 0, 0);
        // 5: restart from CLOSED clears everything; start+stop closes
        step("t5_restart",      0, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t5_vip80",        0, 0, 0, 32'h0,        8'h80, 0,  4, 1, 1, 0, 0);
        step("t5_startstop",    0, 1, 1, 32'h0,        8'h00, 0,  4, 1, 0, 1, 0);
        step("t5_after",        0, 0, 0, 32'h0,        8'h00, 0,  4, 1, 0, 0, 0);
        // 3: start-cycle votes dropped; stop-cycle votes counted
        step("t3_start",        0, 1, 0, 32'hFFFF_FFFF, 8'h00, 0,  0, 0, 1, 0, 0);
        step("t3_zero",         0, 0, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t3_stopvote",     0, 0, 1, 32'h0000_0001, 8'h00, 0,  1, 1, 0, 1, 0);
        step("t3_closed",       0, 0, 1, 32'hFFFF_FFFF, 8'h00, 0,  1, 1, 0, 0, 0);
        step("t3_closed2",      0, 0, 0, 32'h0,        8'hFF, 1,  1, 1, 0, 0, 0);
        // start while OPEN is ignored (no clear)
        step("t3b_start",       0, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t3b_vote",        0, 0, 0, 32'h0000_0001, 8'h00, 0,  1, 1, 1, 0, 0);
        step("t3b_start_ign",   0, 1, 0, 32'h0000_0003, 8'h00, 0,  2, 2, 1, 0, 0);
        // 6: asynchronous reset mid-session
        step("t6_stop",         0, 0, 1, 32'h0,        8'h00, 0,  2, 2, 0, 1, 0);
        step("t6_start",        0, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t6_vote",         0, 0, 0, 32'h0000_000F, 8'h01, 0,  8, 5, 1, 0, 0);

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async/result", int'(result8), 0);
        check("t6_async/voters", int'(voters8), 0);
        check("t6_async/open",   int'(open8),   0);
        check("t6_async/done",   int'(done8),   0);
        check("t6_async/sat",    int'(sat8),    0);
        @(posedge clk);
        #1;
        check("t6_inreset/done", int'(done8), 0);
        @(negedge clk);
        reset = 1'b1;

        step("t6_idle_votes",   0, 0, 1, 32'h0000_000F, 8'h01, 0,  0, 0, 0, 0, 0);
        step("t6_restart",      0, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t6_vote2",        0, 0, 0, 32'h0000_0001, 8'h00, 0,  1, 1, 1, 0, 0);
        step("t6_close",        0, 0, 1, 32'h0,        8'h00, 0,  1, 1, 0, 1, 0);

        // 4: RES_W=6 instance, saturation and exact-limit boundary
        step("t4_start",        1, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t4_burst",        1, 0, 0, 32'hFFFF_FFFF, 8'hFF, 1, 63, 41, 1, 0, 1);
        step("t4_stop",         1, 0, 1, 32'h0,        8'h00, 0, 63, 41, 0, 1, 1);
        step("t4_restart",      1, 1, 0, 32'h0,        8'h00, 0,  0, 0, 1, 0, 0);
        step("t4_exact",        1, 0, 0, 32'h7FFF_FFFF, 8'h0F, 1, 63, 36, 1, 0, 0);
        step("t4_over",         1, 0, 0, 32'hFFFF_FFFF, 8'h0F, 1, 63, 37, 1, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("drain/queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
